// File: rtl/pipe_carry_adder.sv
// pipe_carry_adder: segmented carry-pipelined adder/subtractor.
// Stage k adds operand segment k with the carry registered by stage k-1.
// Each stage register carries the full operands and the partial sum, so
// upper operand segments are skewed and finished lower result segments are
// deskewed by the same registers, and a whole result leaves in one beat.
// The last stage register is the output register. A single global enable
// stalls every stage at once, which preserves order and bubbles.
module pipe_carry_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    // One segment of ripple addition with carry in and carry out.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c);
        return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
    endfunction

    // Stage inputs: stage 0 is fed from the ports, stage k from register k-1.
    logic [WIDTH-1:0]  a_src_s [STAGES];
    logic [WIDTH-1:0]  b_src_s [STAGES];  // effective B (already inverted for sub)
    logic [WIDTH-1:0]  s_src_s [STAGES];
    logic [STAGES-1:0] c_src_s;
    logic [STAGES-1:0] v_src_s;

    // Stage registers and their next-state values.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_q;

    // Status flags, computed as the last stage completes and then registered.
    logic zero_q, neg_q, ovf_q;
    logic zero_d, neg_d, ovf_d;

    logic en_s;

    // Whole pipeline advances only when the output slot is empty or drained.
    assign en_s     = !v_q[LAST] || out_ready;
    assign in_ready = en_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_first
            // sub is folded into the effective B here; it travels with the
            // transaction as the stored (possibly inverted) operand.
            assign a_src_s[k] = a;
            assign b_src_s[k] = sub ? ~b : b;
            assign s_src_s[k] = {WIDTH{1'b0}};
            assign c_src_s[k] = cin;
            assign v_src_s[k] = in_valid && en_s;
        end else begin : g_rest
            assign a_src_s[k] = a_q[k-1];
            assign b_src_s[k] = b_q[k-1];
            assign s_src_s[k] = s_q[k-1];
            assign c_src_s[k] = c_q[k-1];
            assign v_src_s[k] = v_q[k-1];
        end
    end

    // Per-stage segment adders: fill segment k of the partial sum.
    always_comb begin
        logic [SEG:0] seg_v;
        seg_v = {(SEG+1){1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            seg_v  = seg_add(a_src_s[k][k*SEG +: SEG],
                             b_src_s[k][k*SEG +: SEG],
                             c_src_s[k]);
            s_d[k] = s_src_s[k];
            s_d[k][k*SEG +: SEG] = seg_v[SEG-1:0];
            c_d[k] = seg_v[SEG];
        end
    end

    // Result flags derived from the completed sum entering the output register.
    always_comb begin
        zero_d = (s_d[LAST] == {WIDTH{1'b0}});
        neg_d  = s_d[LAST][MSB];
        ovf_d  = (a_src_s[LAST][MSB] == b_src_s[LAST][MSB]) &&
                 (s_d[LAST][MSB] != a_src_s[LAST][MSB]);
    end

    // Stage registers: shift together on enable, hold otherwise; data only
    // loads behind a valid slot so bubbles leave the held values untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= {WIDTH{1'b0}};
                b_q[k] <= {WIDTH{1'b0}};
                s_q[k] <= {WIDTH{1'b0}};
            end
            c_q    <= {STAGES{1'b0}};
            v_q    <= {STAGES{1'b0}};
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en_s) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_src_s[k];
                if (v_src_s[k]) begin
                    a_q[k] <= a_src_s[k];
                    b_q[k] <= b_src_s[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (v_src_s[LAST]) begin
                zero_q <= zero_d;
                neg_q  <= neg_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/pipe_carry_adder.md
PIPE_CARRY_ADDER -- requirements
Module: pipe_carry_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter SEG, default 4: carry-chain segment width; WIDTH SHALL be an integer multiple of SEG; STAGES = WIDTH/SEG.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  operand set accepted on this edge when in_valid is high.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry in (for sub=1, 1 means no borrow).
REQ-010 sub  input  1  0 = A+B+cin; 1 = A+~B+cin.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result on this edge when out_valid is high.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of bit WIDTH-1.
REQ-015 zero  output  1  sum == 0.
REQ-016 neg  output  1  sum[WIDTH-1].
REQ-017 ovf  output  1  two's-complement signed overflow.

Function
REQ-018 The block SHALL be a STAGES-deep pipeline; stage k (0-based) SHALL add segment k, bits [k*SEG+SEG-1 : k*SEG], using the carry registered by stage k-1 (stage 0 uses cin).
REQ-019 Upper operand segments SHALL be skew-delayed, and completed lower result segments deskewed, so that all segments of one transaction leave together.
REQ-020 Effective B SHALL be b when sub=0, ~b when sub=1; sub SHALL be captured with the operands and travel with the transaction.
REQ-021 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en.
REQ-022 When en is high, every stage register, including its valid bit, SHALL shift by one stage; when en is low, all stage registers SHALL hold.
REQ-023 Stage-0 valid SHALL load in_valid && in_ready; bubbles SHALL propagate as invalid stages and are not collapsed.
REQ-024 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid high, with no stall in between.
REQ-025 Throughput SHALL be one transaction per cycle while out_ready stays high.
REQ-026 Results SHALL leave in acceptance order, with no loss and no duplication under any out_ready pattern.
REQ-027 sum, cout, zero, neg and ovf SHALL be registered and SHALL stay stable while out_valid && !out_ready.
REQ-028 ovf = (a[MSB] == beff[MSB]) && (sum[MSB] != a[MSB]), where beff is the effective B.
REQ-029 Carry into each segment SHALL wrap with no saturation; sum is modulo 2^WIDTH.
REQ-030 With STAGES=1, the block SHALL degenerate to a single registered adder with latency 1.
REQ-031 Operand inputs SHALL be ignored when in_valid is low or in_ready is low.

Reset
REQ-032 Asserting reset SHALL immediately clear all valid bits; out_valid=0, sum=0, cout=0, zero=0, neg=0, ovf=0.
REQ-033 In-flight transactions SHALL be discarded on reset.
REQ-034 in_ready SHALL be 1 while reset is high and after release.
REQ-035 The first edge after reset release SHALL accept input normally.

Verification (WIDTH=16, SEG=4 unless stated)
REQ-036 a=FFFF, b=0001, cin=0, sub=0 -> 4 cycles later: sum=0000, cout=1, zero=1, neg=0, ovf=0.
REQ-037 a=8000, b=0001, cin=1, sub=1 -> sum=7FFF, cout=1, ovf=1, neg=0, zero=0.
REQ-038 a=7FFF, b=0001, cin=0, sub=0 -> sum=8000, cout=0, ovf=1, neg=1.
REQ-039 20 random back-to-back ops with out_ready random at 50% -> results match the reference model in order; in_ready low exactly while out_valid && !out_ready; outputs stable during stall.
REQ-040 Reset pulsed with 3 ops in flight -> out_valid falls without waiting for a clock edge; none of the 3 results ever appears; a new op issued after release returns 4 cycles later.
REQ-041 WIDTH=8, SEG=8: a=FF, b=01, cin=1, sub=0 -> 1 cycle later: sum=01, cout=1, ovf=0.
